// File: rtl/watchdog_reset_gen.sv
// Kickable watchdog: warns ahead of the timeout, then requests a fixed-width user_rst pulse.
// States: IDLE 00 disarmed | RUN 01 counting | WARN 10 near timeout | FIRE 11 driving user_rst
module watchdog_reset_gen #(
  parameter int unsigned N          = 32,
  parameter int unsigned FREQ       = 50,
  parameter int unsigned TIMEOUT_MS = 1000,
  parameter int unsigned WARN_MS    = 100,
  parameter int unsigned PULSE_CYC  = 16,
  // cycles per ms per MHz; only lowered to shrink the time base in fast simulations
  parameter int unsigned CYC_PER_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wdt_en,
  input  logic       kick,
  output logic       user_rst,
  output logic       wdt_warn,
  output logic [1:0] wdt_state,
  output logic [7:0] trip_cnt
);

  localparam int unsigned TO_CYC   = TIMEOUT_MS * CYC_PER_MS * FREQ;
  localparam int unsigned WARN_CYC = (TIMEOUT_MS - WARN_MS) * CYC_PER_MS * FREQ;
  localparam logic [N-1:0] TO_LAST   = N'(TO_CYC - 1);
  localparam logic [N-1:0] WARN_LAST = N'(WARN_CYC - 1);
  localparam int PW = $clog2(PULSE_CYC + 1);
  localparam logic [PW-1:0] PULSE_END = PW'(PULSE_CYC);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_WARN = 2'b10;
  localparam logic [1:0] S_FIRE = 2'b11;

  logic [1:0]    state;
  logic [N-1:0]  cnt;
  logic [PW-1:0] pcnt;
  logic          kick_q;
  logic          kick_ev;

  assign kick_ev   = kick & ~kick_q;
  assign wdt_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pcnt     <= '0;
      kick_q   <= 1'b0;
      user_rst <= 1'b0;
      wdt_warn <= 1'b0;
      trip_cnt <= 8'd0;
    end else begin
      kick_q <= kick;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (wdt_en) state <= S_RUN;
        end
        S_RUN: begin
          if (!wdt_en) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (kick_ev) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + N'(1);
            if (cnt == WARN_LAST) begin
              state    <= S_WARN;
              wdt_warn <= 1'b1;
            end
          end
        end
        S_WARN: begin
          if (!wdt_en) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wdt_warn <= 1'b0;
          end else if (kick_ev) begin
            state    <= S_RUN;
            cnt      <= '0;
            wdt_warn <= 1'b0;
          end else if (cnt == TO_LAST) begin
            // cnt holds here; FIRE clears it on exit
            state    <= S_FIRE;
            pcnt     <= '0;
            wdt_warn <= 1'b0;
            if (trip_cnt != 8'hFF) trip_cnt <= trip_cnt + 8'd1;
          end else begin
            cnt <= cnt + N'(1);
          end
        end
        S_FIRE: begin
          if (pcnt == PULSE_END) begin
            user_rst <= 1'b0;
            cnt      <= '0;
            state    <= wdt_en ? S_RUN : S_IDLE;
          end else begin
            pcnt     <= pcnt + PW'(1);
            user_rst <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_watchdog_reset_gen.sv
// Bench for watchdog_reset_gen: age-based reference model checked every cycle, directed scenarios
// on a 2000-cycle-timeout instance and a saturation/random run on a scaled-down instance.
module tb_watchdog_reset_gen;

  typedef struct {
    int   mode;   // 0 disarmed, 1 armed, 2 firing
    int   age;    // cycles since the timer was last restarted
    int   fa;     // cycles spent firing
    int   trips;
    logic kq;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n, en, kick, ur, warn;
  logic [1:0] st;
  logic [7:0] trip;
  logic f_rst_n, f_en, f_kick, f_ur, f_warn;
  logic [1:0] f_st;
  logic [7:0] f_trip;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  bit   f_done = 0;
  mdl_t m, fm;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  watchdog_reset_gen #(.N(32), .FREQ(1), .TIMEOUT_MS(2), .WARN_MS(1), .PULSE_CYC(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .wdt_en(en), .kick(kick),
    .user_rst(ur), .wdt_warn(warn), .wdt_state(st), .trip_cnt(trip));

  watchdog_reset_gen #(.N(16), .FREQ(1), .TIMEOUT_MS(2), .WARN_MS(1), .PULSE_CYC(2),
                       .CYC_PER_MS(4)) u_fast (
    .clk(clk), .rst_n(f_rst_n), .wdt_en(f_en), .kick(f_kick),
    .user_rst(f_ur), .wdt_warn(f_warn), .wdt_state(f_st), .trip_cnt(f_trip));

  function automatic void mstep(inout mdl_t s, input logic rn, input logic e, input logic k,
                                input int tc, input int pc);
    logic ev;
    if (!rn) begin
      s.mode = 0; s.age = 0; s.fa = 0; s.trips = 0; s.kq = 1'b0;
      return;
    end
    ev   = k & ~s.kq;
    s.kq = k;
    case (s.mode)
      0: if (e) s.mode = 1;
      1: begin
        if (!e) begin
          s.mode = 0; s.age = 0;
        end else if (ev) begin
          s.age = 0;
        end else if (s.age == tc - 1) begin
          s.mode = 2; s.fa = 0;
          if (s.trips < 255) s.trips++;
        end else begin
          s.age++;
        end
      end
      default: begin
        s.fa++;
        if (s.fa == pc + 1) begin
          s.mode = e ? 1 : 0;
          s.age  = 0;
        end
      end
    endcase
  endfunction

  function automatic int m_state(mdl_t s, int wc);
    if (s.mode == 0) return 0;
    if (s.mode == 2) return 3;
    return (s.age >= wc) ? 2 : 1;
  endfunction

  function automatic int m_warn(mdl_t s, int wc);
    return (s.mode == 1 && s.age >= wc) ? 1 : 0;
  endfunction

  function automatic int m_rst(mdl_t s);
    return (s.mode == 2 && s.fa >= 1) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    mstep(m, rst_n, en, kick, 2000, 16);
    mstep(fm, f_rst_n, f_en, f_kick, 8, 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(st), m_state(m, 1000));
      chk("warn", int'(warn), m_warn(m, 1000));
      chk("user_rst", int'(ur), m_rst(m));
      chk("trip_cnt", int'(trip), m.trips);
      chk("f_state", int'(f_st), m_state(fm, 4));
      chk("f_warn", int'(f_warn), m_warn(fm, 4));
      chk("f_user_rst", int'(f_ur), m_rst(fm));
      chk("f_trip_cnt", int'(f_trip), fm.trips);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // which: 0 state RUN, 1 warn high, 2 user_rst high
  task automatic wait_for(input string nm, input int which, input int limit);
    int n = 0;
    bit hit;
    hit = (which == 0) ? (st == 2'd1) : (which == 1) ? warn : ur;
    while (!hit && n < limit) begin
      step();
      n++;
      hit = (which == 0) ? (st == 2'd1) : (which == 1) ? warn : ur;
    end
    if (!hit) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_width(input string nm, input bit disturb);
    int w = 0;
    while (ur && w < 100) begin
      if (disturb) begin
        en   = 1'($urandom_range(0, 1));
        kick = 1'($urandom_range(0, 1));
      end
      step();
      w++;
    end
    chk(nm, w, 16);
  endtask

  initial begin
    int t0;
    int n;
    bit seen;
    rst_n = 1'b0; en = 1'b0; kick = 1'b0;
    repeat (3) step();
    chk_en = 1;
    chk("reset_state", int'(st), 0);
    chk("reset_trip", int'(trip), 0);
    chk("reset_rst", int'(ur), 0);

    // free-running timeout
    rst_n = 1'b1; en = 1'b1;
    wait_for("t1_run", 0, 10);
    t0 = cyc;
    wait_for("t1_warn", 1, 1500);
    chk("t1_warn_delay", cyc - t0, 1000);
    wait_for("t1_fire", 2, 1500);
    chk("t1_rst_delay", cyc - t0, 2001);
    pulse_width("t1_pulse_w", 0);
    chk("t1_trip", int'(trip), 1);
    chk("t1_back_run", int'(st), 1);

    // regular kicks keep it quiet
    do_reset();
    seen = 0;
    for (int i = 1; i <= 10000; i++) begin
      kick = (i % 900 == 0);
      step();
      if (ur || warn) seen = 1;
    end
    kick = 1'b0;
    chk("t2_quiet", int'(seen), 0);
    chk("t2_trip", int'(trip), 0);

    // kick while warning
    do_reset();
    wait_for("t3_run", 0, 10);
    repeat (1500) step();
    chk("t3_in_warn", int'(warn), 1);
    kick = 1'b1;
    step();
    kick = 1'b0;
    t0 = cyc;
    chk("t3_warn_drop", int'(warn), 0);
    chk("t3_state", int'(st), 1);
    seen = 0;
    repeat (1990) begin
      step();
      if (ur) seen = 1;
    end
    chk("t3_no_early_fire", int'(seen), 0);
    wait_for("t3_fire", 2, 100);
    chk("t3_fire_delay", cyc - t0, 2001);
    repeat (20) step();

    // kick edge exactly on the timeout cycle, then held high
    do_reset();
    wait_for("t4_run", 0, 10);
    repeat (1999) step();
    kick = 1'b1;
    step();
    t0 = cyc;
    chk("t4_state", int'(st), 1);
    chk("t4_no_rst", int'(ur), 0);
    wait_for("t4_fire", 2, 2100);
    chk("t4_held_delay", cyc - t0, 2001);
    repeat (20) step();
    kick = 1'b0;

    // disarm during warn; disturb inputs during a pulse
    do_reset();
    wait_for("t5_run", 0, 10);
    repeat (1100) step();
    chk("t5_in_warn", int'(warn), 1);
    en = 1'b0;
    step();
    chk("t5_idle", int'(st), 0);
    chk("t5_warn_off", int'(warn), 0);
    seen = 0;
    repeat (50) begin
      step();
      if (ur) seen = 1;
    end
    chk("t5_no_rst", int'(seen), 0);
    en = 1'b1;
    wait_for("t5_fire", 2, 2200);
    pulse_width("t5_pulse_w", 1);
    en = 1'b1; kick = 1'b0;
    repeat (5) step();

    // reset mid-pulse
    do_reset();
    wait_for("t6_fire", 2, 2200);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_abort", int'(ur), 0);
    chk("t6_trip_clear", int'(trip), 0);
    rst_n = 1'b1;

    // random traffic
    repeat (8000) begin
      if ($urandom_range(0, 499) == 0) en = ~en;
      if ($urandom_range(0, 1199) == 0) kick = ~kick;
      rst_n = ($urandom_range(0, 3999) != 0);
      step();
    end

    n = 0;
    while (!f_done && n < 20000) begin
      step();
      n++;
    end
    if (!f_done) chk("fast_done_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    f_rst_n = 1'b0; f_en = 1'b0; f_kick = 1'b0;
    repeat (3) step();
    f_rst_n = 1'b1; f_en = 1'b1;
    repeat (3300) step();
    chk("f_trip_sat", int'(f_trip), 255);
    repeat (4000) begin
      f_en    = ($urandom_range(0, 9) != 0);
      f_kick  = ($urandom_range(0, 3) == 0);
      f_rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    f_done = 1;
  end

endmodule
